// File: rtl/fp16_add_sched_pkg.sv
// ---------------------------------------------------------------------------
// fp16_sched_pkg
//   Shared types and defaults for the FP16 adder scheduler.
//   fp16_t       : raw IEEE-754 binary16 bit pattern (never interpreted here).
//   rsp_entry_t  : result FIFO entry {requester id, sum}; the id field is sized
//                  for the largest supported requester count (16).
// ---------------------------------------------------------------------------
package fp16_sched_pkg;

  typedef logic [15:0] fp16_t;

  localparam int MAX_ID_W       = 4;
  localparam int DEF_ADD_LAT    = 3;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    fp16_t               sum;
  } rsp_entry_t;

endpackage

// File: rtl/fp16_add_sched_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with show-ahead read and modulo pointers, so DEPTH need
//   not be a power of two. A push and a pop in the same cycle are accepted at
//   any occupancy, including full.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     push, din     write request and data
//     pop           read request (head is consumed)
//     dout          head entry; zero while empty
//     empty, full   occupancy flags
//     count         number of stored entries
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  // A write into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, otherwise an unassigned path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, and dout is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && empty));

endmodule

// File: rtl/fp16_add_sched.sv
// ---------------------------------------------------------------------------
// fp16_add_sched
//   Round-robin scheduler sharing one fixed-latency, non-stallable FP16 adder
//   among NUM_REQ requesters. Results return through a tagged FIFO in grant
//   order. Issue is credit-limited so the FIFO can never overflow.
//   Ports:
//     clk, rst                  clock, asynchronous active-high reset
//     req_valid/req_ready       per-requester handshake (ready one-hot or 0)
//     req_a/req_b               packed operands, requester i at [16i+15:16i]
//     add_in_valid/_a/_b        registered issue to the external adder
//     add_out_valid/_sum        adder result, ADD_LAT cycles after issue
//     rsp_valid/rsp_ready       result handshake
//     rsp_id/rsp_sum            requester id and sum of the head result
//     busy                      any operation in flight or buffered
// ---------------------------------------------------------------------------
module fp16_add_sched
  import fp16_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADD_LAT    = DEF_ADD_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*16-1:0] req_b,
  output logic                  add_in_valid,
  output logic [15:0]           add_in_a,
  output logic [15:0]           add_in_b,
  input  logic                  add_out_valid,
  input  logic [15:0]           add_out_sum,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_sum,
  output logic                  busy
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int GUARD_W = $clog2(ADD_LAT + 2);

  // Unpacked views of the operand buses.
  fp16_t a_arr [NUM_REQ];
  fp16_t b_arr [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[16*i +: 16];
    assign b_arr[i] = req_b[16*i +: 16];
  end

  logic [ID_W-1:0]              ptr_q, ptr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         add_in_valid_q, add_in_valid_d;
  fp16_t                        add_in_a_q, add_in_a_d;
  fp16_t                        add_in_b_q, add_in_b_d;
  logic [ADD_LAT:0]             tag_v_q, tag_v_d;
  logic [ADD_LAT:0][ID_W-1:0]   tag_id_q, tag_id_d;
  logic [GUARD_W-1:0]           guard_q, guard_d;

  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_found;
  logic             grant;
  logic             pop;
  logic             fifo_push;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  rsp_entry_t       push_entry;
  rsp_entry_t       head_entry;

  // Rotating priority search starting at ptr.
  always_comb begin
    cand      = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // A credit is the guarantee of a free FIFO slot when the result returns.
  assign grant     = gnt_found && (cnt_q < CNT_W'(FIFO_DEPTH));
  assign req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    add_in_valid_d = grant;
    add_in_a_d     = add_in_a_q;
    add_in_b_d     = add_in_b_q;
    guard_d        = guard_q;
    if (grant) begin
      ptr_d      = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      add_in_a_d = a_arr[gnt_idx];
      add_in_b_d = b_arr[gnt_idx];
    end
    case ({grant, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    // Stage 0 loads with the issue register; stage ADD_LAT meets add_out_valid.
    tag_v_d  = {tag_v_q[ADD_LAT-1:0], grant};
    tag_id_d = {tag_id_q[ADD_LAT-1:0], gnt_idx};
    // Counts cycles since reset; the adder may still deliver stale results
    // issued before reset during this window.
    if (guard_q != GUARD_W'(ADD_LAT + 1)) guard_d = guard_q + GUARD_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q          <= '0;
      cnt_q          <= '0;
      add_in_valid_q <= 1'b0;
      add_in_a_q     <= '0;
      add_in_b_q     <= '0;
      tag_v_q        <= '0;
      tag_id_q       <= '0;
      guard_q        <= '0;
    end else begin
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      add_in_valid_q <= add_in_valid_d;
      add_in_a_q     <= add_in_a_d;
      add_in_b_q     <= add_in_b_d;
      tag_v_q        <= tag_v_d;
      tag_id_q       <= tag_id_d;
      guard_q        <= guard_d;
    end
  end

  assign add_in_valid = add_in_valid_q;
  assign add_in_a     = add_in_a_q;
  assign add_in_b     = add_in_b_q;

  // Results are accepted on the tag, not on add_out_valid, so stale adder
  // outputs after a reset are dropped.
  assign fifo_push  = tag_v_q[ADD_LAT];
  assign push_entry = '{id: MAX_ID_W'(tag_id_q[ADD_LAT]), sum: add_out_sum};

  sync_fifo #(
    .WIDTH($bits(rsp_entry_t)),
    .DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  (push_entry),
    .pop  (pop),
    .dout (head_entry),
    .empty(fifo_empty),
    .full (fifo_full),
    .count(fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_id    = ID_W'(head_entry.id);
  assign rsp_sum   = head_entry.sum;
  assign busy      = (cnt_q != '0);

  a_tag_has_result: assert property (@(posedge clk) disable iff (rst)
    tag_v_q[ADD_LAT] |-> add_out_valid);
  a_result_has_tag: assert property (@(posedge clk) disable iff (rst)
    (add_out_valid && guard_q == GUARD_W'(ADD_LAT + 1)) |-> tag_v_q[ADD_LAT]);
  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !pop));
  a_fifo_within_credit: assert property (@(posedge clk) disable iff (rst)
    fifo_count <= cnt_q);

endmodule

// File: tb/tb_fp16_add_sched.sv
// ---------------------------------------------------------------------------
// tb_fp16_add_sched
//   Bench for fp16_add_sched with a behavioural fixed-latency FP16 adder.
//   Expected results are queued on each observed grant and compared when the
//   DUT returns them. A standalone sync_fifo instance covers the full-FIFO
//   simultaneous push/pop case, which the credit scheme never exposes at top.
// ---------------------------------------------------------------------------
module tb_fp16_add_sched;

  localparam int NUM_REQ    = 4;
  localparam int ADD_LAT    = 3;
  localparam int FIFO_DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*16-1:0] req_a = '0;
  logic [NUM_REQ*16-1:0] req_b = '0;
  logic                  add_in_valid;
  logic [15:0]           add_in_a, add_in_b;
  logic                  add_out_valid;
  logic [15:0]           add_out_sum;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [1:0]            rsp_id;
  logic [15:0]           rsp_sum;
  logic                  busy;

  // Standalone FIFO
  logic       f_push = 1'b0, f_pop = 1'b0;
  logic [7:0] f_din = '0, f_dout;
  logic       f_empty, f_full;
  logic [2:0] f_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fp16_add_sched #(
    .NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_in_valid(add_in_valid), .add_in_a(add_in_a), .add_in_b(add_in_b),
    .add_out_valid(add_out_valid), .add_out_sum(add_out_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(4)) u_fifo_tb (
    .clk(clk), .rst(rst), .push(f_push), .din(f_din), .pop(f_pop),
    .dout(f_dout), .empty(f_empty), .full(f_full), .count(f_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural FP16 adder (via real arithmetic) ----------
  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) begin m = real'(h[9:0]) / 1024.0; e = -14; end
    else        begin m = 1.0 + real'(h[9:0]) / 1024.0; e = e - 15; end
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    int   e;
    int   man;
    real  m;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    man = $rtoi((m - 1.0) * 1024.0 + 0.5);
    if (man == 1024) begin man = 0; e++; end
    return {s, 5'(e + 15), 10'(man)};
  endfunction

  function automatic logic [15:0] fp16_add_model(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) + h2r(b));
  endfunction

  // Not reset, like a real pipelined adder: results in flight survive rst.
  logic [ADD_LAT-1:0] am_v = '0;
  logic [15:0]        am_s [ADD_LAT];
  always @(posedge clk) begin
    am_v    <= {am_v[ADD_LAT-2:0], add_in_valid};
    am_s[0] <= fp16_add_model(add_in_a, add_in_b);
    for (int i = 1; i < ADD_LAT; i++) am_s[i] <= am_s[i-1];
  end
  assign add_out_valid = am_v[ADD_LAT-1];
  assign add_out_sum   = am_s[ADD_LAT-1];

  // ---------------- vectors ------------------------------------------------
  typedef struct { logic [15:0] a; logic [15:0] b; logic [15:0] sum; } vec_t;
  vec_t vecs [8];

  typedef struct { logic [1:0] id; logic [15:0] sum; } exp_t;
  exp_t        sb [$];
  int          grant_log [$];
  logic [15:0] cur_exp [NUM_REQ];
  int          n_grants = 0, n_pops = 0, max_out = 0;

  task automatic set_req(input int id, input vec_t v);
    req_a[id*16 +: 16] = v.a;
    req_b[id*16 +: 16] = v.b;
    cur_exp[id]        = v.sum;
  endtask

  // ---------------- monitor / scoreboard -----------------------------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      sb.delete();
      grant_log.delete();
      n_grants = 0;
      n_pops   = 0;
      max_out  = 0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{id: 2'(i), sum: cur_exp[i]});
          grant_log.push_back(i);
          n_grants++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_pops++;
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_id), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("sb_rsp_id", 32'(rsp_id), 32'(e.id));
          check("sb_rsp_sum", 32'(rsp_sum), 32'(e.sum));
        end
      end
      if (n_grants - n_pops > max_out) max_out = n_grants - n_pops;
    end
  end

  // ---------------- helper tasks -------------------------------------------
  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || am_v != '0) && n < 200) begin @(negedge clk); n++; end
    check("drain_in_time", 32'(n < 200), 32'd1);
  endtask

  task automatic issue_one(input int id, input vec_t v);
    int n;
    n = 0;
    @(posedge clk); #1;
    set_req(id, v);
    req_valid = 4'(1 << id);
    @(negedge clk);
    while (!req_ready[id] && n < 50) begin @(negedge clk); n++; end
    check("grant_in_time", 32'(n < 50), 32'd1);
    @(posedge clk); #1 req_valid = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence -------------------------------------------
  initial begin : main
    int lat;
    int rv_seen;

    vecs[0] = '{16'h3C00, 16'h4000, 16'h4200};  // 1 + 2 = 3
    vecs[1] = '{16'h4000, 16'h4000, 16'h4400};  // 2 + 2 = 4
    vecs[2] = '{16'h3800, 16'h3800, 16'h3C00};  // 0.5 + 0.5 = 1
    vecs[3] = '{16'h4200, 16'hBC00, 16'h4000};  // 3 - 1 = 2
    vecs[4] = '{16'h4500, 16'h4500, 16'h4900};  // 5 + 5 = 10
    vecs[5] = '{16'h0000, 16'h3C00, 16'h3C00};  // 0 + 1 = 1
    vecs[6] = '{16'hC000, 16'hC000, 16'hC400};  // -2 + -2 = -4
    vecs[7] = '{16'h3C00, 16'h3400, 16'h3D00};  // 1 + 0.25 = 1.25
    for (int i = 0; i < NUM_REQ; i++) cur_exp[i] = '0;

    // Reset values
    #1 rst = 1'b1;
    #2;
    check("rst_add_in_valid", 32'(add_in_valid), 32'd0);
    check("rst_add_in_a", 32'(add_in_a), 32'd0);
    check("rst_add_in_b", 32'(add_in_b), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    // Single operation with latency tracking
    @(posedge clk); #1;
    set_req(0, vecs[0]);
    req_valid = 4'b0001;
    @(negedge clk);
    check("single_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    check("single_issue_valid", 32'(add_in_valid), 32'd1);
    check("single_issue_a", 32'(add_in_a), 32'h3C00);
    check("single_issue_b", 32'(add_in_b), 32'h4000);
    check("single_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("idle_issue_valid", 32'(add_in_valid), 32'd0);
    check("idle_issue_a_hold", 32'(add_in_a), 32'h3C00);
    lat = 2;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    check("single_latency", 32'(lat), 32'd5);
    check("single_rsp_id", 32'(rsp_id), 32'd0);
    check("single_rsp_sum", 32'(rsp_sum), 32'h4200);
    @(negedge clk);
    check("single_busy_after_pop", 32'(busy), 32'd0);
    check("single_rsp_valid_after_pop", 32'(rsp_valid), 32'd0);

    // Table of vectors spread over requesters
    for (int i = 0; i < 8; i++) issue_one(i % NUM_REQ, vecs[i]);
    drain();
    check("table_all_returned", 32'(n_pops), 32'(n_grants));
    check("table_sb_empty", 32'(sb.size()), 32'd0);

    // Round robin: all four requesters held valid for 8 cycles
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, vecs[i]);
    @(posedge clk); #1 req_valid = 4'hF;
    repeat (8) @(posedge clk);
    #1 req_valid = '0;
    drain();
    check("rr_grant_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check("rr_grant_order", 32'(grant_log[i]), 32'(i % NUM_REQ));
    check("rr_sb_empty", 32'(sb.size()), 32'd0);

    // Starvation: requesters 1 and 3 continuously valid
    do_reset();
    @(posedge clk); #1 req_valid = 4'b1010;
    repeat (4) @(posedge clk);
    #1 req_valid = '0;
    drain();
    check("starve_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("starve_grant_order", 32'(grant_log[i]), (i % 2 == 0) ? 32'd1 : 32'd3);

    // Backpressure: consumer stalled, credits must cap issue at FIFO_DEPTH
    do_reset();
    rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid = 4'hF;
    repeat (20) @(negedge clk);
    check("bp_grant_count", 32'(n_grants), 32'(FIFO_DEPTH));
    check("bp_req_ready_zero", 32'(req_ready), 32'd0);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_head_id", 32'(rsp_id), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1 req_valid = '0;
    drain();
    check("bp_max_outstanding", 32'(max_out), 32'(FIFO_DEPTH));
    check("bp_no_loss", 32'(n_pops), 32'(n_grants));
    check("bp_sb_empty", 32'(sb.size()), 32'd0);
    check("bp_more_grants", 32'(n_grants > FIFO_DEPTH), 32'd1);

    // Standalone FIFO: full, then push and pop in the same cycle
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 f_push = 1'b1; f_din = 8'(8'hA0 + i);
    end
    @(posedge clk); #1 f_push = 1'b0;
    @(negedge clk);
    check("fifo_full_count", 32'(f_count), 32'd4);
    check("fifo_full_flag", 32'(f_full), 32'd1);
    check("fifo_full_head", 32'(f_dout), 32'hA0);
    @(posedge clk); #1 f_push = 1'b1; f_pop = 1'b1; f_din = 8'hA4;
    @(posedge clk); #1 f_push = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) check("fifo_simul_count", 32'(f_count), 32'd4);
      check("fifo_drain_order", 32'(f_dout), 32'(8'hA0 + i));
      @(posedge clk);
    end
    #1 f_pop = 1'b0;
    @(negedge clk);
    check("fifo_empty_after_drain", 32'(f_empty), 32'd1);
    check("fifo_count_after_drain", 32'(f_count), 32'd0);

    // Reset with three operations in flight
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, vecs[i]);
    @(posedge clk); #1 req_valid = 4'b0111;
    repeat (3) @(posedge clk);
    #1 req_valid = '0;
    #2 rst = 1'b1;
    #1;
    check("midrst_add_in_valid", 32'(add_in_valid), 32'd0);
    check("midrst_add_in_a", 32'(add_in_a), 32'd0);
    check("midrst_add_in_b", 32'(add_in_b), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_id", 32'(rsp_id), 32'd0);
    check("midrst_rsp_sum", 32'(rsp_sum), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    rv_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) rv_seen++;
    end
    check("postrst_no_rsp", 32'(rv_seen), 32'd0);
    check("postrst_busy", 32'(busy), 32'd0);

    // Pointer returned to 0: a fresh all-valid burst starts at requester 0
    @(posedge clk); #1 req_valid = 4'hF;
    @(posedge clk); #1 req_valid = '0;
    drain();
    check("postrst_first_grant", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'd0);
    check("postrst_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp16_add_sched.md
Name: fp16_add_sched

Overview:
- Round-robin scheduler that shares one fixed-latency, non-stallable FP16 adder pipeline (align / add / normalize) among NUM_REQ requesters, such as systolic-array row accumulators.
- Accepts operand pairs over valid/ready handshakes and issues at most one pair per cycle to the adder.
- Tracks each in-flight operation's requester ID in a tag shift pipe.
- Buffers returning sums in a result FIFO with tagged valid/ready output.
- Credit-based issue guarantees the FIFO never overflows, because the adder cannot be stalled.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ADD_LAT, 3, cycles from adder input valid to adder result valid.
- FIFO_DEPTH, 8, result FIFO entries; must be >= ADD_LAT+1.
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester operand pair valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*16  packed FP16 operand A; requester i is at [16i+15:16i].
- req_b  in  NUM_REQ*16  packed FP16 operand B.
- add_in_valid  out  1  operand pair valid to adder.
- add_in_a  out  16  operand A to adder.
- add_in_b  out  16  operand B to adder.
- add_out_valid  in  1  adder result valid; asserted exactly ADD_LAT cycles after add_in_valid.
- add_out_sum  in  16  adder FP16 result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  requester that issued the operation.
- rsp_sum  out  16  FP16 sum.
- busy  out  1  any operation in flight or buffered.

Behaviour:
- Reset values:
  - add_in_valid=0, add_in_a=0, add_in_b=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, busy=0.
  - RR pointer=0, credit count=0, tag pipe all invalid, FIFO empty.
- Credits:
  - cnt = operations granted but not yet popped from the FIFO (in flight plus buffered).
  - Grant is allowed only when cnt < FIFO_DEPTH.
  - cnt increments on grant and decrements on FIFO pop; if both happen in the same cycle, cnt is unchanged.
- Arbitration (combinational):
  - If the credit check passes, grant the first i with req_valid[i]=1, searching from ptr upward and wrapping at NUM_REQ.
  - req_ready[g]=1 only for the granted index g; all other bits are 0.
  - req_ready never depends on a requester's own valid beyond selection.
- Handshake:
  - A transfer occurs when req_valid[i] and req_ready[i] are both 1.
  - Requesters hold valid and data stable until accepted.
- Pointer update: on a grant, ptr <= (g+1) mod NUM_REQ. With no grant, ptr holds.
- Issue stage (registered):
  - Cycle after a grant: add_in_valid=1, add_in_a/add_in_b = the granted operands.
  - With no grant: add_in_valid=0 and the operands hold their previous values.
- Tag pipe:
  - ADD_LAT+1 stages of {valid, id}.
  - Stage 0 is loaded on grant alongside the issue register; the pipe shifts every cycle.
  - The final stage aligns with add_out_valid.
- FIFO write:
  - When the final tag stage is valid, push {id, add_out_sum}.
  - add_out_valid is checked against the tag valid; a mismatch asserts in simulation only.
- FIFO read:
  - rsp_valid = FIFO not empty; rsp_id/rsp_sum come from the head entry (show-ahead).
  - Pop when rsp_valid and rsp_ready are both 1.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - Overflow is impossible by construction; an overflow asserts in simulation.
- Latency:
  - Minimum grant-to-rsp_valid latency is ADD_LAT+2 cycles (issue register, adder, FIFO write).
  - Sustained throughput is 1 operation per cycle while rsp_ready=1.
- busy = (cnt != 0).
- Reset mid-operation:
  - All tags, FIFO contents and credits are cleared.
  - Adder results arriving after reset are discarded because their tags are invalid.
  - The pointer returns to 0.
- Order: results emerge in grant order, across all requesters.

Decomposition:
- Package fp16_sched_pkg:
  - typedef fp16_t (logic [15:0]).
  - typedef rsp_entry_t (packed struct {id, sum}).
  - constants DEF_ADD_LAT=3 and DEF_FIFO_DEPTH=8.
- One sub-module sync_fifo, parameterised by width and depth:
  - power-of-two or modulo pointers, plus a count output.
  - asynchronous active-high reset.
  - show-ahead read.

Test Plan:
- Single op, NUM_REQ=4, ADD_LAT=3:
  - Stimulus: req0 a=0x3C00, b=0x4000; rsp_ready=1.
  - Required: req_ready[0] in cycle 0; add_in_valid in cycle 1; rsp_valid in cycle 5 with rsp_id=0, rsp_sum=0x4200 (model adder); busy falls after the pop.
- Round robin:
  - Stimulus: all four requesters held valid for 8 cycles.
  - Required: grants 0,1,2,3,0,1,2,3; rsp_id follows the same sequence.
- Starvation check:
  - Stimulus: req1 and req3 continuously valid, ptr=0.
  - Required: grants alternate 1,3,1,3.
- Backpressure:
  - Stimulus: rsp_ready=0 with all requesters valid.
  - Required: exactly 8 grants, then req_ready=0; FIFO never exceeds 8.
  - Then raise rsp_ready: one grant per pop, with no lost or duplicated results.
- Simultaneous events: FIFO full, a push and a pop in the same cycle.
  - Required: count stays 8 and the head advances correctly.
- Reset mid-flight:
  - Stimulus: assert rst asynchronously with 3 ops in flight.
  - Required: all outputs go to their reset values immediately.
  - After rst releases, the in-flight adder outputs produce no rsp_valid and cnt=0.
